// File: rtl/move_sequencer.sv
// Turns button presses into paced single-cell moves of the active tile on the board.
// Presses are edge-detected, qualified by enable flags and board edges, then animated over STEPS ticks.
module move_sequencer #(
    parameter int STEPS = 8,
    parameter int ROWS  = 4,
    parameter int COLS  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       up_en,
    input  logic       down_en,
    input  logic       left_en,
    input  logic       right_en,
    output logic [1:0] pos_row,
    output logic [2:0] pos_col,
    output logic [1:0] dir,
    output logic       busy,
    output logic       step,
    output logic       done,
    output logic       blocked
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);
    localparam logic [2:0] LAST_COL = 3'(COLS - 1);
    localparam logic [7:0] LAST_CNT = 8'(STEPS - 1);

    state_t     state_r;
    logic [3:0] prev_btn_r;
    logic [7:0] cnt_r;
    logic [1:0] pos_row_r;
    logic [2:0] pos_col_r;
    logic [1:0] dir_r;
    logic       busy_r;
    logic       step_r;
    logic       done_r;
    logic       blocked_r;

    logic [3:0] btn_s;
    logic [3:0] en_s;
    logic [3:0] press_s;
    logic [1:0] sel_dir_s;
    logic       at_edge_s;
    logic       legal_s;

    // Press edges, fixed-priority direction pick and legality of that direction.
    always_comb begin
        btn_s     = {btn_right, btn_left, btn_down, btn_up};
        en_s      = {right_en, left_en, down_en, up_en};
        press_s   = btn_s & ~prev_btn_r;
        sel_dir_s = 2'd0;
        at_edge_s = 1'b1;
        if (press_s[0]) begin
            sel_dir_s = 2'd0;
        end else if (press_s[1]) begin
            sel_dir_s = 2'd1;
        end else if (press_s[2]) begin
            sel_dir_s = 2'd2;
        end else begin
            sel_dir_s = 2'd3;
        end
        case (sel_dir_s)
            2'd0:    at_edge_s = (pos_row_r == 2'd0);
            2'd1:    at_edge_s = (pos_row_r == LAST_ROW);
            2'd2:    at_edge_s = (pos_col_r == 3'd0);
            2'd3:    at_edge_s = (pos_col_r == LAST_COL);
            default: at_edge_s = 1'b1;
        endcase
        legal_s = en_s[sel_dir_s] & ~at_edge_s;
    end

    // Sequencer state, step counter, committed position and pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= HOLD;
            prev_btn_r <= 4'd0;
            cnt_r      <= 8'd0;
            pos_row_r  <= 2'd0;
            pos_col_r  <= 3'd0;
            dir_r      <= 2'd0;
            busy_r     <= 1'b0;
            step_r     <= 1'b0;
            done_r     <= 1'b0;
            blocked_r  <= 1'b0;
        end else begin
            prev_btn_r <= btn_s;
            step_r     <= 1'b0;
            done_r     <= 1'b0;
            blocked_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (|press_s) begin
                        dir_r <= sel_dir_s;
                        if (legal_s) begin
                            cnt_r   <= 8'd0;
                            busy_r  <= 1'b1;
                            state_r <= MOVE;
                        end else begin
                            blocked_r <= 1'b1;
                            state_r   <= HOLD;
                        end
                    end
                end
                MOVE: begin
                    if (tick) begin
                        step_r <= 1'b1;
                        cnt_r  <= cnt_r + 8'd1;
                        // The tick that reaches STEPS commits the move in the same cycle.
                        if (cnt_r == LAST_CNT) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= HOLD;
                            case (dir_r)
                                2'd0:    pos_row_r <= pos_row_r - 2'd1;
                                2'd1:    pos_row_r <= pos_row_r + 2'd1;
                                2'd2:    pos_col_r <= pos_col_r - 3'd1;
                                2'd3:    pos_col_r <= pos_col_r + 3'd1;
                                default: pos_row_r <= pos_row_r;
                            endcase
                        end
                    end
                end
                HOLD: begin
                    if (btn_s == 4'd0) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= HOLD;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign pos_row = pos_row_r;
    assign pos_col = pos_col_r;
    assign dir     = dir_r;
    assign busy    = busy_r;
    assign step    = step_r;
    assign done    = done_r;
    assign blocked = blocked_r;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed and randomized bench for move_sequencer against a move-level reference model.
module tb_move_sequencer;

    localparam int STEPS = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 6;

    logic       clk = 1'b0;
    logic       rst, tick;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       up_en, down_en, left_en, right_en;
    logic [1:0] pos_row;
    logic [2:0] pos_col;
    logic [1:0] dir;
    logic       busy, step, done, blocked;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_row  = 0;
    int exp_col  = 0;
    int exp_dir  = 0;

    move_sequencer #(.STEPS(STEPS), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .up_en(up_en), .down_en(down_en), .left_en(left_en), .right_en(right_en),
        .pos_row(pos_row), .pos_col(pos_col), .dir(dir),
        .busy(busy), .step(step), .done(done), .blocked(blocked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] m);
        {btn_right, btn_left, btn_down, btn_up} = m;
    endtask

    task automatic set_en(input logic [3:0] e);
        {right_en, left_en, down_en, up_en} = e;
    endtask

    // Quiet outputs with the model's position and last direction.
    task automatic check_quiet(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".step"}, step, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".blocked"}, blocked, 0);
        check({tag, ".row"}, pos_row, exp_row);
        check({tag, ".col"}, pos_col, exp_col);
        check({tag, ".dir"}, dir, exp_dir);
    endtask

    function automatic int pick(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic bit legal(input int d, input logic [3:0] e);
        case (d)
            0:       return e[0] && exp_row > 0;
            1:       return e[1] && exp_row < ROWS - 1;
            2:       return e[2] && exp_col > 0;
            3:       return e[3] && exp_col < COLS - 1;
            default: return 0;
        endcase
    endfunction

    // One press transaction: press, optional move with gaps between ticks, hold, release.
    task automatic do_move(input logic [3:0] mask, input logic [3:0] e, input int gap,
                           input int hold, input bit tick_on_press, input bit wiggle);
        int d;
        bit ok;
        set_en(e);
        set_btn(mask);
        tick = tick_on_press;
        cyc();
        tick = 1'b0;
        d  = pick(mask);
        ok = legal(d, e);
        exp_dir = d;
        check("press.busy", busy, ok);
        check("press.blocked", blocked, !ok);
        check("press.dir", dir, d);
        check("press.step", step, 0);
        if (ok) begin
            for (int k = 1; k <= STEPS; k++) begin
                for (int g = 0; g < gap; g++) begin
                    if (wiggle) begin
                        set_btn(mask | 4'($urandom_range(0, 15)));
                        set_en(4'($urandom_range(0, 15)));
                    end
                    cyc();
                    check("gap.step", step, 0);
                    check("gap.busy", busy, 1);
                    check("gap.done", done, 0);
                end
                tick = 1'b1;
                cyc();
                tick = 1'b0;
                if (k == STEPS) begin
                    case (d)
                        0: exp_row--;
                        1: exp_row++;
                        2: exp_col--;
                        default: exp_col++;
                    endcase
                end
                check("tick.step", step, 1);
                check("tick.done", done, k == STEPS);
                check("tick.busy", busy, k != STEPS);
                check("tick.row", pos_row, exp_row);
                check("tick.col", pos_col, exp_col);
            end
        end else begin
            cyc();
            check_quiet("blk");
        end
        set_btn(mask);
        for (int h = 0; h < hold; h++) begin
            tick = 1'($urandom_range(0, 1));
            cyc();
            check_quiet("hold");
        end
        tick = 1'b0;
        set_btn(4'd0);
        cyc();
        check_quiet("rel");
    endtask

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        set_btn(4'b1000);
        set_en(4'b1111);
        // Reset held three cycles with btn_right high.
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_quiet("reset");
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1;
            cyc();
            check_quiet("postrst");
        end
        tick = 1'b0;
        set_btn(4'd0);
        cyc();
        check_quiet("postrst.rel");

        do_move(4'b0100, 4'b0100, 1, 2, 0, 0);   // left at col 0: blocked
        do_move(4'b1000, 4'b1000, 2, 2, 1, 0);   // basic right, tick every 3 cycles
        do_move(4'b1000, 4'b0111, 0, 1, 0, 0);   // right disabled: blocked
        do_move(4'b0010, 4'b1111, 0, 1, 0, 0);   // down to (1,1)
        do_move(4'b1001, 4'b1111, 1, 1, 0, 0);   // up+right: up wins
        do_move(4'b0010, 4'b1111, 0, 8, 0, 1);   // held down: one move only
        do_move(4'b0010, 4'b1111, 0, 1, 0, 0);   // re-press: second move

        // Reset in the middle of a move.
        set_en(4'b1111);
        set_btn(4'b1000);
        cyc();
        check("mid.busy", busy, 1);
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1;
            cyc();
            check("mid.step", step, 1);
        end
        tick = 1'b0;
        rst = 1'b1;
        exp_row = 0;
        exp_col = 0;
        exp_dir = 0;
        cyc();
        rst = 1'b0;
        check_quiet("midrst");
        for (int i = 0; i < 6; i++) begin
            tick = 1'b1;
            cyc();
            check_quiet("midrst.after");
        end
        tick = 1'b0;
        set_btn(4'd0);
        cyc();
        check_quiet("midrst.rel");

        // Random presses, enables and tick spacing.
        for (int t = 0; t < 40; t++) begin
            do_move(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
